// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two registered read ports, one byte-enabled
// write port, and a sequential clear sweep that zeroes one entry per cycle.
// Ports:
//   CLK, RST                 clock, async active-low reset
//   WrEn/WrAddr/WrData/WrBe  write request, address, data, byte enables
//   RdEnA/RdAddrA            read port A request/address -> RdDataA, RdValidA
//   RdEnB/RdAddrB            read port B request/address -> RdDataB, RdValidB
//   ClrReq                   start a clear sweep (ignored while Busy)
//   Busy                     high while the sweep runs (DEPTH cycles)
//   WrDrop                   pulse: last cycle's write was discarded
module regfile_2r1w #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDRESS = 3,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WrEn,
    input  logic [ADDRESS-1:0]   WrAddr,
    input  logic [WIDTH-1:0]     WrData,
    input  logic [WIDTH/8-1:0]   WrBe,
    input  logic                 RdEnA,
    input  logic [ADDRESS-1:0]   RdAddrA,
    input  logic                 RdEnB,
    input  logic [ADDRESS-1:0]   RdAddrB,
    output logic [WIDTH-1:0]     RdDataA,
    output logic [WIDTH-1:0]     RdDataB,
    output logic                 RdValidA,
    output logic                 RdValidB,
    input  logic                 ClrReq,
    output logic                 Busy,
    output logic                 WrDrop
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [ADDRESS-1:0] LAST_IDX = ADDRESS'(DEPTH - 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [0:0]         state_q, state_d;
    logic [ADDRESS-1:0] ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic [WIDTH-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic               vld_a_q, vld_a_d, vld_b_q, vld_b_d;

    logic               wr_ok_c;
    logic [WIDTH-1:0]   wr_old_c;
    logic [WIDTH-1:0]   wr_merged_c;

    function automatic logic in_range(input logic [ADDRESS-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Accepted write and its byte-merged result
    always_comb begin
        wr_ok_c     = WrEn && (state_q == S_IDLE) && in_range(WrAddr);
        wr_old_c    = in_range(WrAddr) ? mem_q[WrAddr] : '0;
        wr_merged_c = wr_old_c;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (WrBe[b]) wr_merged_c[b*8 +: 8] = WrData[b*8 +: 8];
        end
    end

    // Read ports; forwarding only sees accepted writes, never dropped ones
    always_comb begin
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        vld_a_d = RdEnA;
        vld_b_d = RdEnB;
        if (RdEnA) begin
            if (!in_range(RdAddrA))                                 rd_a_d = '0;
            else if (BYPASS != 0 && wr_ok_c && WrAddr == RdAddrA)   rd_a_d = wr_merged_c;
            else                                                    rd_a_d = mem_q[RdAddrA];
        end
        if (RdEnB) begin
            if (!in_range(RdAddrB))                                 rd_b_d = '0;
            else if (BYPASS != 0 && wr_ok_c && WrAddr == RdAddrB)   rd_b_d = wr_merged_c;
            else                                                    rd_b_d = mem_q[RdAddrB];
        end
    end

    // Clear FSM and array next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (ClrReq) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDRESS'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Writes only land in IDLE, so they never collide with the sweep
        if (wr_ok_c) mem_d[WrAddr] = wr_merged_c;
        busy_d = (state_d == S_CLEAR);
        drop_d = WrEn && !wr_ok_c;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q   <= '{default: '0};
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
        end
    end

    assign RdDataA  = rd_a_q;
    assign RdDataB  = rd_b_q;
    assign RdValidA = vld_a_q;
    assign RdValidB = vld_b_q;
    assign Busy     = busy_q;
    assign WrDrop   = drop_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three instances (8-deep bypass, 8-deep no-bypass,
// 6-deep bypass) share one stimulus stream and are checked against a
// per-instance array model every cycle, plus hand-computed literal checks.
module tb_regfile_2r1w;

    localparam int DEP [3] = '{8, 8, 6};
    localparam bit BYP [3] = '{1'b1, 1'b0, 1'b1};

    logic        CLK, RST, WrEn, ClrReq, RdEnA, RdEnB;
    logic [2:0]  WrAddr, RdAddrA, RdAddrB;
    logic [15:0] WrData;
    logic [1:0]  WrBe;

    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        va [3], vb [3], busy [3], drop [3];

    int n_checks;
    int n_errors;
    bit cmp_en;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDRESS(3), .BYPASS(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrBe(WrBe),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(rda[0]), .RdDataB(rdb[0]), .RdValidA(va[0]), .RdValidB(vb[0]),
        .ClrReq(ClrReq), .Busy(busy[0]), .WrDrop(drop[0]));

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDRESS(3), .BYPASS(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrBe(WrBe),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(rda[1]), .RdDataB(rdb[1]), .RdValidA(va[1]), .RdValidB(vb[1]),
        .ClrReq(ClrReq), .Busy(busy[1]), .WrDrop(drop[1]));

    regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ADDRESS(3), .BYPASS(1)) u_dut2 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrBe(WrBe),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(rda[2]), .RdDataB(rdb[2]), .RdValidA(va[2]), .RdValidB(vb[2]),
        .ClrReq(ClrReq), .Busy(busy[2]), .WrDrop(drop[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [3][8];
    int          m_left [3];       // sweep cycles still to run
    logic [15:0] e_rda [3], e_rdb [3];
    bit          e_va [3], e_vb [3], e_busy [3], e_drop [3];

    function automatic logic [15:0] rd_model(input int k, input logic [2:0] a,
                                             input bit ok, input logic [15:0] mg);
        if (int'(a) >= DEP[k])                 return 16'h0;
        if (BYP[k] && ok && a == WrAddr)       return mg;
        return m_mem[k][a];
    endfunction

    always @(posedge CLK or negedge RST) begin
        bit          bsy, ok;
        logic [15:0] mg;
        if (!RST) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 8; j++) m_mem[k][j] = 16'h0;
                m_left[k] = 0;
                e_rda[k] = 16'h0; e_rdb[k] = 16'h0;
                e_va[k] = 1'b0; e_vb[k] = 1'b0; e_busy[k] = 1'b0; e_drop[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bsy = m_left[k] > 0;
                ok  = WrEn && !bsy && (int'(WrAddr) < DEP[k]);
                mg  = m_mem[k][WrAddr];
                if (WrBe[0]) mg[7:0]  = WrData[7:0];
                if (WrBe[1]) mg[15:8] = WrData[15:8];
                if (RdEnA) e_rda[k] = rd_model(k, RdAddrA, ok, mg);
                if (RdEnB) e_rdb[k] = rd_model(k, RdAddrB, ok, mg);
                e_va[k]   = RdEnA;
                e_vb[k]   = RdEnB;
                e_drop[k] = WrEn && !ok;
                if (bsy) begin
                    m_mem[k][DEP[k] - m_left[k]] = 16'h0;
                    m_left[k]--;
                end
                if (ok) m_mem[k][WrAddr] = mg;
                if (!bsy && ClrReq) m_left[k] = DEP[k];
                e_busy[k] = m_left[k] > 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("m_rdA%0d", k),  32'(rda[k]),  32'(e_rda[k]));
                chk($sformatf("m_rdB%0d", k),  32'(rdb[k]),  32'(e_rdb[k]));
                chk($sformatf("m_vA%0d", k),   32'(va[k]),   32'(e_va[k]));
                chk($sformatf("m_vB%0d", k),   32'(vb[k]),   32'(e_vb[k]));
                chk($sformatf("m_busy%0d", k), 32'(busy[k]), 32'(e_busy[k]));
                chk($sformatf("m_drop%0d", k), 32'(drop[k]), 32'(e_drop[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input bit ea, input logic [2:0] aa,
                        input bit eb, input logic [2:0] ab, input bit clr);
        @(posedge CLK);
        #2;
        WrEn = we; WrAddr = wa; WrData = wd; WrBe = be;
        RdEnA = ea; RdAddrA = aa; RdEnB = eb; RdAddrB = ab; ClrReq = clr;
    endtask

    task automatic idle();
        tick(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        tick(1'b1, a, d, be, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic rd_a(input logic [2:0] a);
        tick(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, a, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int bc0, bc2;
        n_checks = 0; n_errors = 0; cmp_en = 1'b0;
        RST = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0; WrBe = '0;
        RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0; ClrReq = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("rst_rdA", 32'(rda[0]), 32'h0);
        chk("rst_vA",  32'(va[0]),  32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_drop", 32'(drop[0]), 32'h0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        cmp_en = 1'b1;

        // Post-reset reads are zero with valid
        for (int i = 0; i < 8; i++) begin
            rd_a(3'(i));
            idle();
            chk("post_rst_rd", 32'(rda[0]), 32'h0);
            chk("post_rst_vld", 32'(va[0]), 32'h1);
        end

        // Byte-enable merge
        wr(3'd3, 16'h1234, 2'b11);
        wr(3'd3, 16'hABCD, 2'b01);
        rd_a(3'd3);
        idle();
        chk("be_merge0", 32'(rda[0]), 32'h12CD);
        chk("be_merge1", 32'(rda[1]), 32'h12CD);
        chk("be_merge2", 32'(rda[2]), 32'h12CD);

        // Same-cycle read/write of one address
        wr(3'd5, 16'h1111, 2'b11);
        tick(1'b1, 3'd5, 16'h5A5A, 2'b11, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0);
        idle();
        chk("byp_A0", 32'(rda[0]), 32'h5A5A);
        chk("byp_B0", 32'(rdb[0]), 32'h5A5A);
        chk("nobyp_A1", 32'(rda[1]), 32'h1111);
        chk("nobyp_B1", 32'(rdb[1]), 32'h1111);
        chk("byp_A2", 32'(rda[2]), 32'h5A5A);
        rd_a(3'd5);
        idle();
        chk("nobyp_wrote1", 32'(rda[1]), 32'h5A5A);

        // Fill; 6-deep instance drops addresses 6 and 7
        for (int i = 0; i < 6; i++) wr(3'(i), 16'(16'h1111 * (i + 1)), 2'b11);
        wr(3'd6, 16'h7777, 2'b11);
        idle();
        chk("oor_drop2", 32'(drop[2]), 32'h1);
        chk("inr_drop0", 32'(drop[0]), 32'h0);
        wr(3'd7, 16'h8888, 2'b11);
        rd_a(3'd7);
        idle();
        chk("fill_rd7_0", 32'(rda[0]), 32'h8888);
        chk("oor_rd7_2", 32'(rda[2]), 32'h0);
        chk("oor_vld7_2", 32'(va[2]), 32'h1);
        rd_a(3'd5);
        idle();
        chk("oor_nochg5_2", 32'(rda[2]), 32'h6666);

        // Clear sweep with a write attempted while busy
        tick(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        bc0 = 0; bc2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) wr(3'd2, 16'hFFFF, 2'b11);
            else tick(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i % 8), 1'b1, 3'(7 - (i % 8)), 1'b0);
            if (busy[0]) bc0++;
            if (busy[2]) bc2++;
            if (i == 3) chk("busy_wrdrop0", 32'(drop[0]), 32'h1);
        end
        chk("busy_len0", 32'(bc0), 32'd8);
        chk("busy_len2", 32'(bc2), 32'd6);
        for (int i = 0; i < 8; i++) begin
            rd_a(3'(i));
            idle();
            chk("clr_rd0", 32'(rda[0]), 32'h0);
        end

        // Write and ClrReq together: write lands, then the sweep zeroes it
        tick(1'b1, 3'd0, 16'hBEEF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        repeat (10) idle();
        rd_a(3'd0);
        idle();
        chk("wr_then_clr0", 32'(rda[0]), 32'h0);

        // Reset in the middle of a sweep
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h7777, 2'b11);
        rd_a(3'd7);
        tick(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) rd_a(3'd7);
        chk("pre_rst_busy0", 32'(busy[0]), 32'h1);
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_rdA0", 32'(rda[0]), 32'h0);
        chk("mid_rst_rdB0", 32'(rdb[0]), 32'h0);
        chk("mid_rst_vA0", 32'(va[0]), 32'h0);
        chk("mid_rst_busy0", 32'(busy[0]), 32'h0);
        chk("mid_rst_drop0", 32'(drop[0]), 32'h0);
        #1 RST = 1'b1;
        rd_a(3'd7);
        idle();
        chk("after_rst_rd7", 32'(rda[0]), 32'h0);
        chk("after_rst_v7", 32'(va[0]), 32'h1);
        chk("after_rst_busy", 32'(busy[0]), 32'h0);
        repeat (3) idle();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 16: register data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of registers; SHALL satisfy 1 <= DEPTH <= 2**ADDRESS.
REQ-003 Parameter ADDRESS, default 3: address bus width in bits.
REQ-004 Parameter BYPASS, default 1: 1 = write-first same-cycle forwarding; 0 = read returns the pre-write value.
REQ-005 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 WrEn  input  1  write request.
REQ-008 WrAddr  input  ADDRESS  write address.
REQ-009 WrData  input  WIDTH  write data.
REQ-010 WrBe  input  WIDTH/8  byte enables; bit i selects WrData[8i+7:8i].
REQ-011 RdEnA / RdEnB  input  1  read request, ports A / B.
REQ-012 RdAddrA / RdAddrB  input  ADDRESS  read addresses.
REQ-013 RdDataA / RdDataB  output  WIDTH  registered read data.
REQ-014 RdValidA / RdValidB  output  1  one-cycle pulse qualifying RdData.
REQ-015 ClrReq  input  1  start a sequential clear of all registers.
REQ-016 Busy  output  1  high while the clear sweep runs.
REQ-017 WrDrop  output  1  one-cycle pulse: the write of the previous cycle was discarded.

Function
REQ-018 Write: when WrEn=1, Busy=0 and WrAddr<DEPTH, the enabled bytes of entry WrAddr SHALL take WrData at the edge; disabled bytes SHALL hold.
REQ-019 Read latency: RdEnX=1 in cycle N SHALL give RdDataX and RdValidX=1 in cycle N+1; RdValidX=0 when RdEnX was 0.
REQ-020 RdDataX SHALL hold its last value when RdEnX=0.
REQ-021 Reads and writes SHALL be independent; a read and a write in the same cycle SHALL both be performed. Both read ports MAY address the same entry.
REQ-022 Same-cycle read/write of one address with BYPASS=1: RdData SHALL be the merged value (new enabled bytes, old disabled bytes).
REQ-023 Same-cycle read/write of one address with BYPASS=0: RdData SHALL be the value held before the write.
REQ-024 Out of range (address >= DEPTH): writes SHALL be ignored with WrDrop pulsed; reads SHALL return 0 with RdValid=1.
REQ-025 Clear FSM states: IDLE, CLEAR.
REQ-026 IDLE -> CLEAR when ClrReq=1; the sweep pointer SHALL load 0 and Busy SHALL rise the next cycle.
REQ-027 In CLEAR, one entry (pointer) SHALL be zeroed per cycle, with pointer incrementing; after entry DEPTH-1 the FSM SHALL return to IDLE and Busy SHALL fall, so Busy is high for exactly DEPTH cycles.
REQ-028 ClrReq while Busy=1 SHALL be ignored.
REQ-029 WrEn=1 while Busy=1 SHALL not modify the array; WrDrop SHALL pulse the next cycle.
REQ-030 Reads during CLEAR SHALL be served and SHALL return current contents; entries already swept SHALL read 0. Bypass SHALL not apply to dropped writes.
REQ-031 WrEn=1 and ClrReq=1 in the same IDLE cycle: the write SHALL be performed, then the sweep SHALL zero it.

Reset
REQ-032 RST=0 SHALL immediately clear all entries to 0, RdDataA/B to 0, RdValidA/B to 0, Busy to 0, WrDrop to 0, the FSM to IDLE and the pointer to 0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; no clear SHALL resume after release.
REQ-034 The first edge after RST rises SHALL be a normal operating cycle.

Verification
REQ-035 After reset: read A addr 0..7 -> each RdDataA=0x0000, RdValidA=1 one cycle after the request.
REQ-036 Write 0xABCD to addr 3 with WrBe=2'b01, previously 0x1234 -> read gives 0x12CD.
REQ-037 BYPASS=1: write 0x5A5A to addr 5 (WrBe=2'b11) while RdEnA=RdEnB=1 to addr 5 -> both ports return 0x5A5A next cycle; BYPASS=0 -> old value.
REQ-038 Fill addr 0..7 with 0x1111*(i+1), pulse ClrReq -> Busy high for exactly 8 cycles; a write during Busy produces WrDrop=1 and leaves the array unchanged; all reads return 0 afterwards.
REQ-039 Start a clear, assert RST at sweep cycle 3 -> all outputs are 0 immediately; after release Busy=0 and a read of addr 7 returns 0.
REQ-040 DEPTH=6, ADDRESS=3: write addr 6 -> WrDrop=1 and no entry changes; read addr 7 -> 0 with RdValid=1.
